// File: rtl/seu_pkg.sv
// Shared types and helper functions for the SEU counter array.
package seu_pkg;

  // Widest event vector the popcount helper accepts.
  localparam int unsigned MAX_CH = 256;

  // Re-arm filter state; ARMED doubles as the filtered event level.
  typedef enum logic {
    FILT_IDLE  = 1'b0,
    FILT_ARMED = 1'b1
  } filt_state_e;

  // $clog2 that never returns 0, so a 1-entry select still has a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Number of set bits among the lowest n bits of v.
  function automatic int unsigned popcount(input logic [MAX_CH-1:0] v, input int unsigned n);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if ((i < n) && v[i]) c = c + 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/seu_counter_array_if.sv
// Control/readout bundle of the SEU counter array.
interface seu_counter_array_if
  import seu_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned RD_W = clog2_min1(N_CH);

  logic [N_CH-1:0]  seu_in;
  logic [N_CH-1:0]  clr;
  logic             clr_all;
  logic             snap;
  logic [RD_W-1:0]  rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] total;
  logic [N_CH-1:0]  ovf;
  logic             total_ovf;
  logic [N_CH-1:0]  ev_pulse;

  modport master (
    output seu_in, clr, clr_all, snap, rd_sel,
    input  rd_data, total, ovf, total_ovf, ev_pulse
  );

  modport slave (
    input  seu_in, clr, clr_all, snap, rd_sel,
    output rd_data, total, ovf, total_ovf, ev_pulse
  );
endinterface

// File: rtl/seu_channel.sv
// One SEU channel: synchroniser, re-arm filter, edge detect, event counter.
module seu_channel
  import seu_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FILT_LEN   = 8,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seu_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o,
  output logic             ev_pulse_o,
  output logic             ev_c
);
  localparam int unsigned         FILT_W      = clog2_min1(FILT_LEN);
  localparam logic [FILT_W-1:0]   FILT_RELOAD = FILT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  logic              act_c;
  logic              evt_c;
  logic              sync1_q, sync2_q;
  filt_state_e       state_q;
  logic [FILT_W-1:0] fcnt_q;
  logic              evt_d1_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              ev_pulse_q;

  assign act_c = seu_i ^ ACTIVE_LOW;
  assign evt_c = (state_q == FILT_ARMED);
  assign ev_c  = evt_c & ~evt_d1_q;

  // Two-flop synchroniser on the normalised (1 = asserted) flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= act_c;
      sync2_q <= sync1_q;
    end
  end

  // Re-arm filter: stays ARMED until FILT_LEN consecutive inactive samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILT_IDLE;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        FILT_IDLE: begin
          if (sync2_q) begin
            state_q <= FILT_ARMED;
            fcnt_q  <= FILT_RELOAD;
          end
        end
        FILT_ARMED: begin
          if (sync2_q)             fcnt_q  <= FILT_RELOAD;
          else if (fcnt_q != '0)   fcnt_q  <= fcnt_q - FILT_W'(1);
          else                     state_q <= FILT_IDLE;
        end
        default: state_q <= FILT_IDLE;
      endcase
    end
  end

  // Edge detect, counter and sticky overflow; clear beats a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_d1_q   <= 1'b0;
      ev_pulse_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      evt_d1_q   <= evt_c;
      ev_pulse_q <= ev_c;
      if (clr_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (ev_c) begin
        if (cnt_q == CNT_MAX) begin
          ovf_q <= 1'b1;
          if (!SATURATE) cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_o      = cnt_q;
  assign ovf_o      = ovf_q;
  assign ev_pulse_o = ev_pulse_q;

endmodule

// File: rtl/seu_counter_array.sv
// Multi-channel SEU event counter with total, atomic snapshot and readout mux.
module seu_counter_array
  import seu_pkg::*;
#(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FILT_LEN   = 8,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  seu_counter_array_if.slave  bus
);
  localparam int unsigned      SUM_W   = CNT_W + clog2_min1(N_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]  ch_ev;
  logic [N_CH-1:0]  ch_ovf;
  logic [N_CH-1:0]  ch_pulse;
  logic [CNT_W-1:0] ch_cnt   [N_CH];
  logic [CNT_W-1:0] shadow_q [N_CH];
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] total_q;
  logic             total_ovf_q;
  logic [SUM_W-1:0] sum_c;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    seu_channel #(
      .CNT_W     (CNT_W),
      .FILT_LEN  (FILT_LEN),
      .ACTIVE_LOW(ACTIVE_LOW),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .seu_i     (bus.seu_in[i]),
      .clr_i     (bus.clr[i] | bus.clr_all),
      .cnt_o     (ch_cnt[i]),
      .ovf_o     (ch_ovf[i]),
      .ev_pulse_o(ch_pulse[i]),
      .ev_c      (ch_ev[i])
    );
  end

  assign sum_c = SUM_W'(total_q) + SUM_W'(popcount(MAX_CH'(ch_ev), N_CH));

  // Total of all filtered events; only clr_all clears it.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_all) begin
      total_q     <= '0;
      total_ovf_q <= 1'b0;
    end else if (sum_c > SUM_W'(CNT_MAX)) begin
      total_ovf_q <= 1'b1;
      total_q     <= SATURATE ? CNT_MAX : CNT_W'(sum_c);
    end else begin
      total_q <= CNT_W'(sum_c);
    end
  end

  // Snapshot takes pre-update counters; readout is one cycle behind rd_sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) shadow_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (bus.snap) begin
        for (int unsigned i = 0; i < N_CH; i++) shadow_q[i] <= ch_cnt[i];
      end
      rd_data_q <= (32'(bus.rd_sel) < N_CH) ? shadow_q[bus.rd_sel] : '0;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.total     = total_q;
  assign bus.total_ovf = total_ovf_q;
  assign bus.ovf       = ch_ovf;
  assign bus.ev_pulse  = ch_pulse;

endmodule

// File: doc/seu_counter_array.md
Name: seu_counter_array

Overview:
- Multi-channel successor to the single-channel SEU event counter, used in the irradiation test readout path.
- Each channel takes an asynchronous SEU flag from a monitored cell or chain and applies a 2-flop synchroniser.
- Each channel then applies a re-arm glitch filter and counts filtered rising edges.
- Adds parametrised channel count, width and polarity, saturate/wrap mode, per-channel clear, an atomic snapshot for readout, and an all-channel total counter.

Parameters:
- N_CH, 8, number of independent SEU channels (>=1).
- CNT_W, 32, width of each channel counter and of the total counter.
- FILT_LEN, 8, consecutive inactive synchronised samples needed before a channel re-arms (>=1).
- ACTIVE_LOW, 1, 1 = seu_in asserted low; 0 = asserted high.
- SATURATE, 1, 1 = counters hold at all-ones; 0 = counters wrap to 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- seu_in  in  N_CH  asynchronous SEU flags, polarity per ACTIVE_LOW
- clr  in  N_CH  per-channel clear of counter and ovf flag, synchronous
- clr_all  in  1  clears all channel counters, ovf flags, total and total_ovf
- snap  in  1  copies all live channel counters into shadow registers
- rd_sel  in  max(1,$clog2(N_CH))  shadow register select
- rd_data  out  CNT_W  registered shadow[rd_sel]
- total  out  CNT_W  live count of filtered events across all channels
- ovf  out  N_CH  sticky per-channel saturate/wrap flag
- total_ovf  out  1  sticky overflow flag for total
- ev_pulse  out  N_CH  1-cycle pulse per counted event

Behaviour:
- Reset (rst=1 at an edge):
  - Sync flops load the inactive level.
  - Filter state goes idle (evt=0, filter counter=0).
  - All counters, shadows, rd_data, total, ovf, total_ovf and ev_pulse go to 0.
  - rst overrides every other input.
- Input normalisation: act = seu_in XOR ACTIVE_LOW, so act=1 means asserted.
- Pipeline per channel:
  - Input stable before edge 0: sync1 loads at edge 0, sync2 at edge 1, evt at edge 2.
  - Counter and ev_pulse update at edge 3.
  - The new count is therefore visible 3 cycles after the first sampling edge.
- Filter, two states:
  - IDLE(evt=0): sync2=1 -> ARMED(evt=1), filter counter loads FILT_LEN-1.
  - ARMED(evt=1), sync2=1: filter counter reloads FILT_LEN-1.
  - ARMED(evt=1), sync2=0, counter!=0: counter decrements.
  - ARMED(evt=1), sync2=0, counter==0: -> IDLE.
  - Net effect: the channel returns to IDLE after exactly FILT_LEN consecutive inactive samples.
  - Any activity while ARMED does not produce a second count.
- Event detection: evt=1 with evt_d1=0 gives one event and one ev_pulse cycle.
- Channel counter update:
  - Event, counter < max: +1.
  - Event, counter at max, SATURATE=1: counter holds, ovf<=1.
  - Event, counter at max, SATURATE=0: counter wraps to 0, ovf<=1.
  - ovf is sticky until clr or clr_all.
- Clear priority: clr[i] or clr_all in the same cycle as an event -> counter=0 and ovf=0; the event is dropped.
- Channel independence: clr has no effect on the filter or sync state; a channel that is ARMED stays ARMED.
- Total counter:
  - Adds popcount of the event vector in the same edge as the channel counters.
  - Same saturate/wrap rule; sets total_ovf.
  - Per-channel clr does not change total; only clr_all clears total.
  - Saturate: the result clamps at all-ones if the sum exceeds max.
  - Wrap: modulo 2^CNT_W.
- Snapshot:
  - snap at edge k loads each shadow with the counter value before edge k's update.
  - An event in the same cycle is excluded from the shadow but included in the live counter.
  - snap together with clr: the shadow takes the pre-clear value.
- Readout:
  - rd_data <= shadow[rd_sel] every edge, giving 1-cycle latency.
  - rd_sel >= N_CH returns 0.
- Reset mid-event:
  - An input still asserted after rst is released is counted as a new event.
  - It appears 3 cycles after the first post-reset edge.

Decomposition:
- Shared package seu_pkg holds:
  - The filter state encoding (IDLE/ARMED).
  - A function clog2_min1.
  - A popcount function parametrised on N_CH.
- Sub-module seu_channel holds sync, filter, edge detect, counter and ovf for one channel, with parameters CNT_W, FILT_LEN, ACTIVE_LOW and SATURATE.
- The top level holds a generate loop of seu_channel, the total adder, shadows and the read mux.

Test Plan:
- Single pulse: ACTIVE_LOW=1, hold seu_in[0]=0 for 1 cycle then 1 -> ev_pulse[0] at edge 3; counter0=1; total=1; other channels 0.
- Glitch filter: FILT_LEN=8, ch2 active 1 cycle, inactive 5, active 1, then inactive 20 -> counter2=1. Repeat with a gap of 9 inactive cycles -> counter2=2.
- Saturate: CNT_W=4, SATURATE=1, 17 separated events on ch1 -> counter1=15, ovf[1]=1. With SATURATE=0 -> counter1=1, ovf[1]=1. Then clr[1] -> 0 and 0.
- Simultaneous: events on all 8 channels in the same cycle -> total +8 in one edge. Also clr[3] in the ch3 event cycle -> counter3=0, total still +8.
- Snapshot: counter5=6 and a ch5 event land on the same edge as snap -> shadow5=6, live 7. rd_sel=5 -> rd_data=6 one cycle later. rd_sel=9 with N_CH=8 -> rd_data=0.
- Reset: rst asserted while ch0 is held active -> all outputs 0. After release with the input still active -> counter0=1 after 3 cycles.
